sat_stream: RTL and testbench



---
 rtl/sat_pkg.sv | 23 ++
 rtl/sat_lane.sv | 79 +++++++
 rtl/sat_stream.sv | 124 ++++++++++++
 tb/tb_sat_stream.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// Shared saturation mode encoding and the bounds of an OUT_W-bit result.
package sat_pkg;

  typedef enum logic [1:0] {
    SAT_SIGNED    = 2'd0,
    SAT_SYMMETRIC = 2'd1,
    SAT_MAGNITUDE = 2'd2,
    SAT_UNSIGNED  = 2'd3
  } sat_mode_e;

  function automatic int sat_max(input int out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int out_w);
    return -(1 << (out_w - 1));
  endfunction

  function automatic int sat_umax(input int out_w);
    return (1 << out_w) - 1;
  endfunction

endpackage

// File: rtl/sat_lane.sv
// Combinational clamp of one signed IN_W sample to OUT_W bits under a selectable mode.
// All comparisons happen in signed IN_W+1 bits so |MIN_IN| and the unsigned ceiling are representable.
module sat_lane
  import sat_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4
) (
  input  logic [IN_W-1:0]  x,
  input  sat_mode_e        mode,
  output logic [OUT_W-1:0] y,
  output logic             sat
);

  localparam int EXT_W = IN_W + 1;
  localparam logic signed [EXT_W-1:0] C_MAX  = EXT_W'(sat_max(OUT_W));
  localparam logic signed [EXT_W-1:0] C_MIN  = EXT_W'(sat_min(OUT_W));
  localparam logic signed [EXT_W-1:0] C_NMAX = EXT_W'(-sat_max(OUT_W));
  localparam logic signed [EXT_W-1:0] C_UMAX = EXT_W'(sat_umax(OUT_W));
  localparam logic signed [EXT_W-1:0] C_ZERO = '0;

  logic signed [EXT_W-1:0] w_x;
  logic signed [EXT_W-1:0] w_abs;
  logic signed [EXT_W-1:0] w_res;
  logic [EXT_W-1-OUT_W:0]  w_unused_hi;

  assign w_x   = signed'({x[IN_W-1], x});
  assign w_abs = w_x[EXT_W-1] ? -w_x : w_x;

  always_comb begin
    w_res = w_x;
    sat   = 1'b0;
    case (mode)
      SAT_SIGNED: begin
        if (w_x > C_MAX) begin
          w_res = C_MAX;
          sat   = 1'b1;
        end else if (w_x < C_MIN) begin
          w_res = C_MIN;
          sat   = 1'b1;
        end
      end
      SAT_SYMMETRIC: begin
        if (w_x > C_MAX) begin
          w_res = C_MAX;
          sat   = 1'b1;
        end else if (w_x < C_NMAX) begin
          w_res = C_NMAX;
          sat   = 1'b1;
        end
      end
      SAT_MAGNITUDE: begin
        // The sign flip itself is not a clamp; only exceeding MAX flags.
        w_res = w_abs;
        if (w_abs > C_MAX) begin
          w_res = C_MAX;
          sat   = 1'b1;
        end
      end
      SAT_UNSIGNED: begin
        if (w_x < C_ZERO) begin
          w_res = C_ZERO;
          sat   = 1'b1;
        end else if (w_x > C_UMAX) begin
          w_res = C_UMAX;
          sat   = 1'b1;
        end
      end
      default: begin
        w_res = w_x;
        sat   = 1'b0;
      end
    endcase
  end

  assign y           = w_res[OUT_W-1:0];
  assign w_unused_hi = w_res[EXT_W-1:OUT_W];

endmodule

// File: rtl/sat_stream.sv
// Two-stage valid/ready multi-lane saturator: S1 registers samples+mode, S2 registers clamped lanes.
// Optional saturation event counter enabled by SAT_STREAM_STATS_EN.
module sat_stream
  import sat_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4,
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic [1:0]             mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_sat,
  input  logic                   clr_count,
  output logic [CNT_W-1:0]       sat_count
);

  // Handshake: a beat moves on a rising clk edge when valid & ready are both high;
  // valid never depends on ready, and a stage holds its contents while not loaded.
  logic                   r_s1_valid;
  logic [LANES*IN_W-1:0]  r_s1_data;
  sat_mode_e              r_s1_mode;
  logic                   r_s2_valid;
  logic [LANES*OUT_W-1:0] r_s2_data;
  logic [LANES-1:0]       r_s2_sat;

  logic                   w_s1_load;
  logic                   w_s2_load;
  logic [LANES*OUT_W-1:0] w_lane_y;
  logic [LANES-1:0]       w_lane_sat;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mode  <= SAT_SIGNED;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data <= in_data;
        r_s1_mode <= sat_mode_e'(mode);
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sat_lane #(
      .IN_W (IN_W),
      .OUT_W(OUT_W)
    ) u_lane (
      .x   (r_s1_data[g*IN_W +: IN_W]),
      .mode(r_s1_mode),
      .y   (w_lane_y[g*OUT_W +: OUT_W]),
      .sat (w_lane_sat[g])
    );
  end

  // Output payload only changes when a real beat is loaded, so it holds during a stall.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_sat   <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_lane_y;
        r_s2_sat  <= w_lane_sat;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_sat   = r_s2_sat;

`ifdef SAT_STREAM_STATS_EN
  localparam int PC_W  = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + PC_W;
  localparam logic [SUM_W-1:0] C_CNT_MAX = {{PC_W{1'b0}}, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] r_count;
  logic [PC_W-1:0]  w_pop;
  logic [SUM_W-1:0] w_sum;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pop = w_pop + PC_W'(r_s2_sat[i]);
    end
  end

  assign w_sum = SUM_W'(r_count) + SUM_W'(w_pop);

  // Clear wins over a coincident output handshake; that beat's events are dropped.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_count <= '0;
    end else if (clr_count) begin
      r_count <= '0;
    end else if (r_s2_valid && out_ready) begin
      r_count <= (w_sum > C_CNT_MAX) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end
  end

  assign sat_count = r_count;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_count;
  assign sat_count    = '0;
`endif

endmodule

// File: tb/tb_sat_stream.sv
// Directed bench for sat_stream: vector table, streaming, backpressure, reset mid-stream, counter.
module tb_sat_stream;

`ifdef SAT_STREAM_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  typedef struct {
    logic [1:0] mode;
    logic [7:0] l0;
    logic [7:0] l1;
    logic [3:0] y0;
    logic [3:0] y1;
    logic [1:0] sat;
  } vec_t;

  logic             clk;
  logic             rst_b;
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [1:0]       out_sat;
  logic             clr_count;
  logic [CNT_W-1:0] sat_count;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  vec_t vecs[14];

  sat_stream #(
    .IN_W (8),
    .OUT_W(4),
    .LANES(2),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .clr_count(clr_count),
    .sat_count(sat_count)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: present one beat, wait (bounded) for in_ready, record expectation.
  task automatic send_beat(input vec_t v, output int waited);
    waited   = 0;
    mode     = v.mode;
    in_data  = {v.l1, v.l0};
    in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("send_ready", in_ready, 1);
    if (in_ready) begin
      exp_q.push_back({v.sat, v.y1, v.y0});
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain", (exp_q.size() == 0 && !out_valid), 1);
  endtask

  // Scoreboard / monitor: compares every output handshake and stall stability.
  logic [9:0] held;
  bit         hold_vld = 0;
  always @(negedge clk) begin
    #1;
    if (!rst_b) begin
      hold_vld = 0;
    end else if (out_valid && !out_ready) begin
      if (hold_vld) check("stall_stable", {out_sat, out_data}, held);
      held     = {out_sat, out_data};
      hold_vld = 1;
    end else begin
      hold_vld = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_beat: got %0h expected no beat", {out_sat, out_data});
        end else begin
          check("out_beat", {out_sat, out_data}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int   w;
    int   k;
    bit   acc;
    vec_t bp[4];

    rst_b = 1'b0; in_valid = 1'b0; in_data = '0; mode = '0;
    out_ready = 1'b1; clr_count = 1'b0;

    //          mode   l0     l1     y0    y1    sat
    vecs[0]  = '{2'd0, 8'hEE, 8'h12, 4'h8, 4'h7, 2'b11};
    vecs[1]  = '{2'd0, 8'hF9, 8'h05, 4'h9, 4'h5, 2'b00};
    vecs[2]  = '{2'd1, 8'hF8, 8'h80, 4'h9, 4'h9, 2'b11};
    vecs[3]  = '{2'd2, 8'hFC, 8'hFA, 4'h4, 4'h6, 2'b00};
    vecs[4]  = '{2'd2, 8'h80, 8'h0C, 4'h7, 4'h7, 2'b11};
    vecs[5]  = '{2'd3, 8'hFD, 8'h0F, 4'h0, 4'hF, 2'b01};
    vecs[6]  = '{2'd3, 8'h10, 8'h00, 4'hF, 4'h0, 2'b01};
    vecs[7]  = '{2'd0, 8'h07, 8'hF8, 4'h7, 4'h8, 2'b00};
    vecs[8]  = '{2'd1, 8'hF9, 8'h64, 4'h9, 4'h7, 2'b10};
    vecs[9]  = '{2'd2, 8'h00, 8'hF9, 4'h0, 4'h7, 2'b00};
    vecs[10] = '{2'd2, 8'h07, 8'hF8, 4'h7, 4'h7, 2'b10};
    vecs[11] = '{2'd3, 8'h80, 8'h7F, 4'h0, 4'hF, 2'b11};
    vecs[12] = '{2'd0, 8'h80, 8'h7F, 4'h8, 4'h7, 2'b11};
    vecs[13] = '{2'd1, 8'h07, 8'hF8, 4'h7, 4'h9, 2'b10};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_sat_count", sat_count, 0);
    rst_b = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    // Table: isolated beats with latency check
    for (int i = 0; i < 14; i++) begin
      send_beat(vecs[i], w);
      check("lat1_valid", out_valid, 0);
      @(negedge clk);
      check("lat2_valid", out_valid, 1);
      @(negedge clk);
    end
    wait_drain();

    // Full-throughput streaming
    for (int i = 0; i < 14; i++) begin
      send_beat(vecs[i], w);
      check("stream_no_wait", w, 0);
    end
    wait_drain();

    // Backpressure: 4 back-to-back beats, out_ready low for 5 cycles
    bp[0] = vecs[0]; bp[1] = vecs[2]; bp[2] = vecs[4]; bp[3] = vecs[11];
    @(negedge clk);
    out_ready = 1'b0;
    k = 0;
    mode = bp[0].mode; in_data = {bp[0].l1, bp[0].l0}; in_valid = 1'b1;
    for (int c = 0; c < 40 && k < 4; c++) begin
      if (c == 5) begin
        check("bp_accepted", k, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
      end
      #1 acc = in_ready;
      @(negedge clk);
      if (acc) begin
        exp_q.push_back({bp[k].sat, bp[k].y1, bp[k].y0});
        k++;
        if (k < 4) begin
          mode = bp[k].mode; in_data = {bp[k].l1, bp[k].l0};
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    check("bp_all_sent", k, 4);
    wait_drain();

    // Reset with 2 beats in flight
    out_ready = 1'b0;
    send_beat(vecs[0], w);
    send_beat(vecs[2], w);
    rst_b = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_b = 1'b1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_out_data", out_data, 0);
    check("mrst_sat_count", sat_count, 0);
    check("mrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("mrst_no_ghost", out_valid, 0);
    send_beat(vecs[5], w);
    check("mrst_lat1", out_valid, 0);
    @(negedge clk);
    check("mrst_lat2", out_valid, 1);
    wait_drain();

`ifdef SAT_STREAM_STATS_EN
    // Counter: accumulate, saturate, clear-wins
    send_beat(vecs[12], w);
    wait_drain();
    @(negedge clk);
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    check("cnt_clear", sat_count, 0);
    send_beat(vecs[5], w);
    send_beat(vecs[0], w);
    wait_drain();
    check("cnt_three", sat_count, 3);
    send_beat(vecs[8], w);
    wait_drain();
    check("cnt_saturate", sat_count, 3);
    send_beat(vecs[12], w);
    @(negedge clk);
    check("cnt_clr_beat_valid", out_valid, 1);
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    check("cnt_clr_wins", sat_count, 0);
    wait_drain();
`else
    check("cnt_tied_zero", sat_count, 0);
`endif

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
